// File: rtl/mdu_pkg.sv
// Shared types and opcode decode helpers for the iterative multiply/divide unit.
package mdu_pkg;

    localparam int XLEN_DEF = 32;

    // RV32M funct3 encodings
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mdu_state_e;

    // Divide family (DIV/DIVU/REM/REMU): funct3 bit 2 set
    function automatic logic op_is_div(input logic [2:0] op);
        case (op)
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

    // Ops returning the remainder rather than the quotient
    function automatic logic op_is_rem(input logic [2:0] op);
        case (op)
            OP_REM, OP_REMU: return 1'b1;
            default:         return 1'b0;
        endcase
    endfunction

    // rs1 is interpreted as two's complement
    function automatic logic rs1_is_signed(input logic [2:0] op);
        case (op)
            OP_MULH, OP_MULHSU, OP_DIV, OP_REM: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // rs2 is interpreted as two's complement
    function automatic logic rs2_is_signed(input logic [2:0] op);
        case (op)
            OP_MULH, OP_DIV, OP_REM: return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One combinational iteration of the magnitude multiply (shift-add) or
// restoring divide (shift-subtract-restore) on a shared 2*XLEN+1 accumulator.
//   multiply: acc = {0, hi, lo};  lo holds the remaining multiplier bits
//   divide:   acc = {rem, quo};   quo shifts in one quotient bit per step
module mdu_iter_step
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              is_div,
    input  logic [2*XLEN:0]   acc_i,
    input  logic [XLEN-1:0]   b_i,
    output logic [2*XLEN:0]   acc_o
);

    logic [XLEN:0]   mul_sum;
    logic [XLEN+1:0] rem_sh;
    logic [XLEN+1:0] rem_diff;
    logic [XLEN+1:0] rem_sel;
    logic            ge;

    // Compute both step flavours and select by operation class
    always_comb begin
        if (acc_i[0]) begin
            mul_sum = acc_i[2*XLEN:XLEN] + {1'b0, b_i};
        end else begin
            mul_sum = acc_i[2*XLEN:XLEN];
        end

        rem_sh   = acc_i[2*XLEN:XLEN-1];
        ge       = (rem_sh >= {2'b00, b_i});
        rem_diff = rem_sh - {2'b00, b_i};
        rem_sel  = ge ? rem_diff : rem_sh;

        if (is_div) begin
            // Upper remainder bits are always zero after restore; fold them into the spare bit
            acc_o = {|rem_sel[XLEN+1:XLEN], rem_sel[XLEN-1:0], acc_i[XLEN-2:0], ge};
        end else begin
            acc_o = {1'b0, mul_sum, acc_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/mdu_seq_ctrl.sv
// Sequencer for the iterative RV32M unit: accepts one op from execute, stalls
// the pipeline for XLEN iterations, applies sign fix-up and strobes done.
// Divide-by-zero and signed overflow resolve immediately (IDLE -> DONE).
module mdu_seq_ctrl
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN);
    localparam int ACC_W = 2 * XLEN + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] cneg(input logic [XLEN-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cneg2(input logic [2*XLEN-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    mdu_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [XLEN-1:0]  b_q, b_d;
    mdu_op_e          op_q, op_d;
    logic             negp_q, negp_d;
    logic             negr_q, negr_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic             done_q, done_d;

    logic             a_neg, b_neg;
    logic [XLEN-1:0]  a_mag, b_mag;
    logic             div0, ovf;
    logic [XLEN-1:0]  special_res;
    logic [ACC_W-1:0] acc_step;
    logic             div_q;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]  final_res;

    // Operand sign/magnitude split and special-case detection at latch time
    always_comb begin
        a_neg = rs1_is_signed(op) & rs1[XLEN-1];
        b_neg = rs2_is_signed(op) & rs2[XLEN-1];
        a_mag = cneg(rs1, a_neg);
        b_mag = cneg(rs2, b_neg);
        div0  = op_is_div(op) && (rs2 == '0);
        ovf   = ((op == OP_DIV) || (op == OP_REM)) && (rs1 == MIN_NEG) && (rs2 == '1);
        if (div0) begin
            special_res = op_is_rem(op) ? rs1 : '1;
        end else begin
            special_res = op_is_rem(op) ? '0 : MIN_NEG;
        end
    end

    assign div_q = op_is_div(op_q);

    mdu_iter_step #(
        .XLEN (XLEN)
    ) u_step (
        .is_div (div_q),
        .acc_i  (acc_q),
        .b_i    (b_q),
        .acc_o  (acc_step)
    );

    // Final sign correction and word selection from the last iteration's output
    always_comb begin
        prod_fix = cneg2(acc_step[2*XLEN-1:0], negp_q);
        case (op_q)
            OP_MUL:                       final_res = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              final_res = cneg(acc_step[XLEN-1:0], negp_q);
            default:                      final_res = cneg(acc_step[2*XLEN-1:XLEN], negr_q);
        endcase
    end

    // Next-state, datapath load and stall decode
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        b_d      = b_q;
        op_d     = op_q;
        negp_d   = negp_q;
        negr_d   = negr_q;
        result_d = result_q;
        done_d   = 1'b0;
        stall    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    stall  = 1'b1;
                    op_d   = mdu_op_e'(op);
                    b_d    = b_mag;
                    acc_d  = {{(XLEN+1){1'b0}}, a_mag};
                    negp_d = a_neg ^ b_neg;
                    negr_d = a_neg;
                    cnt_d  = '0;
                    if (div0 || ovf) begin
                        state_d  = DONE;
                        result_d = special_res;
                        done_d   = 1'b1;
                    end else begin
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                stall = 1'b1;
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d  = DONE;
                        result_d = final_res;
                        done_d   = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    // Datapath registers (operands, accumulator, sign flags) need no reset
    always_ff @(posedge clk) begin
        acc_q  <= acc_d;
        b_q    <= b_d;
        op_q   <= op_d;
        negp_q <= negp_d;
        negr_q <= negr_d;
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign result = result_q;

endmodule
